serial_comparator: RTL and testbench

SERIAL_COMPARATOR -- requirements
Module: serial_comparator

---
 rtl/serial_comparator.sv | 58 +++++
 tb/tb_serial_comparator.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_comparator.sv
// Bit-serial magnitude comparator: operands arrive LSB first, one bit pair per clock.
// The most recent differing bit pair decides the result, so a three-state Moore FSM suffices.
module serial_comparator (
    input  logic clk,
    input  logic a,
    input  logic b,
    input  logic reset,
    output logic greater,
    output logic equal,
    output logic less
);

    typedef enum logic [1:0] {
        EQ = 2'b00,
        GT = 2'b01,
        LT = 2'b10
    } state_t;

    state_t state;
    state_t state_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EQ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = EQ;
        greater    = 1'b0;
        equal      = 1'b0;
        less       = 1'b0;

        // A differing pair is more significant than anything seen so far; equal pairs hold.
        case (state)
            EQ, GT, LT: begin
                if (a && !b) begin
                    state_next = GT;
                end else if (!a && b) begin
                    state_next = LT;
                end else begin
                    state_next = state;
                end
            end
            default: state_next = EQ;
        endcase

        // Outputs come from the state register alone; the illegal encoding reads as equal.
        case (state)
            GT:      greater = 1'b1;
            LT:      less    = 1'b1;
            default: equal   = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_serial_comparator.sv
// Bench for serial_comparator: directed scenarios plus randomized streams checked
// against a prefix-comparison model built from the bit history.
module tb_serial_comparator;

    logic clk;
    logic a;
    logic b;
    logic reset;
    logic greater;
    logic equal;
    logic less;

    int checks = 0;
    int errors = 0;

    // Expected {greater, equal, less} after each rising edge.
    logic [2:0] exp_q[$];
    logic       a_hist[$];
    logic       b_hist[$];

    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_EQ = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;

    serial_comparator dut (
        .clk     (clk),
        .a       (a),
        .b       (b),
        .reset   (reset),
        .greater (greater),
        .equal   (equal),
        .less    (less)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare the numbers formed by the bit histories: the latest differing bit is the MSB that differs.
    function automatic logic [2:0] model_result();
        for (int i = a_hist.size() - 1; i >= 0; i--) begin
            if (a_hist[i] != b_hist[i]) begin
                return a_hist[i] ? R_GT : R_LT;
            end
        end
        return R_EQ;
    endfunction

    task automatic check_model();
        logic [2:0] obs;
        logic [2:0] exp;
        obs = {greater, equal, less};
        checks++;
        assert ($countones(obs) == 1 && !$isunknown(obs))
        else begin
            errors++;
            $error("FAIL onehot observed=%b required=one-hot", obs);
        end
        checks++;
        assert (exp_q.size() != 0)
        else begin
            errors++;
            $error("FAIL exp_q_empty observed=%0d required=nonzero", exp_q.size());
        end
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            checks++;
            assert (obs === exp)
            else begin
                errors++;
                $error("FAIL model observed=%b required=%b", obs, exp);
            end
        end
    endtask

    // Inputs change on the falling edge; outputs are checked 1 ns before the next rising edge.
    task automatic drive(input logic ia, input logic ib, input logic ir);
        @(negedge clk);
        a     = ia;
        b     = ib;
        reset = ir;
        #4;
        check_model();
        @(posedge clk);
        if (ir) begin
            a_hist.delete();
            b_hist.delete();
        end else begin
            a_hist.push_back(ia);
            b_hist.push_back(ib);
        end
        exp_q.push_back(model_result());
    endtask

    task automatic expect_now(input string tag, input logic [2:0] exp);
        logic [2:0] obs;
        #1;
        obs = {greater, equal, less};
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b required=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] va;
        logic [7:0] vb;
        logic       ra;
        logic       rb;
        logic       rr;

        a     = 1'b0;
        b     = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        exp_q.push_back(R_EQ);
        expect_now("reset_state", R_EQ);

        // Scenario 1: 48 vs 48
        va = 8'd48;
        vb = 8'd48;
        drive(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(va[i], vb[i], 1'b0);
            expect_now("s1_equal", R_EQ);
        end

        // Scenario 2: 32 vs 11
        drive(1'b1, 1'b1, 1'b1);
        expect_now("s2_reset", R_EQ);
        va = 8'd32;
        vb = 8'd11;
        for (int i = 0; i < 8; i++) begin
            drive(va[i], vb[i], 1'b0);
            expect_now("s2_bit", (i < 5) ? R_LT : R_GT);
        end

        // Scenario 3: 37 vs 53
        drive(1'b0, 1'b1, 1'b1);
        expect_now("s3_reset", R_EQ);
        va = 8'd37;
        vb = 8'd53;
        for (int i = 0; i < 8; i++) begin
            drive(va[i], vb[i], 1'b0);
            expect_now("s3_bit", (i < 4) ? R_EQ : R_LT);
        end

        // Scenario 4: reset mid-stream with a differing pair present
        drive(1'b0, 1'b0, 1'b1);
        va = 8'd32;
        vb = 8'd11;
        for (int i = 0; i < 6; i++) begin
            drive(va[i], vb[i], 1'b0);
        end
        expect_now("s4_greater", R_GT);
        drive(1'b1, 1'b0, 1'b1);
        expect_now("s4_reset_discard", R_EQ);
        drive(1'b0, 1'b1, 1'b0);
        expect_now("s4_fresh_lt", R_LT);
        drive(1'b1, 1'b0, 1'b0);
        expect_now("s4_fresh_gt", R_GT);

        // Scenario 5: one greater pair then 20 equal pairs
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        expect_now("s5_first", R_GT);
        for (int i = 0; i < 20; i++) begin
            ra = 1'($urandom_range(0, 1));
            drive(ra, ra, 1'b0);
            expect_now("s5_hold", R_GT);
        end

        // Reset held for several edges with random data
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            expect_now("reset_hold", R_EQ);
        end

        // Zero-length and long all-equal streams stay equal
        for (int i = 0; i < 12; i++) begin
            ra = 1'($urandom_range(0, 1));
            drive(ra, ra, 1'b0);
        end
        expect_now("equal_stream", R_EQ);

        // Randomized streams with occasional resets
        for (int i = 0; i < 400; i++) begin
            ra = 1'($urandom_range(0, 1));
            rb = ($urandom_range(0, 3) == 0) ? !ra : ra;
            rr = ($urandom_range(0, 24) == 0);
            drive(ra, rb, rr);
        end

        // Final edge result
        @(negedge clk);
        a     = 1'b0;
        b     = 1'b0;
        reset = 1'b0;
        #4;
        check_model();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
